// File: rtl/frame_filler.sv
// Write-side DDR2 engine: fills the 800x600 framebuffer with one colour by
// pushing one write command plus two 128-bit beats per 8-pixel block.
module frame_filler #(
    parameter logic [5:0] FB_BASE = 6'd1,
    parameter logic [6:0] LAST_X  = 7'd99,
    parameter logic [9:0] LAST_Y  = 10'd599
) (
    input  logic         cpu_clk_g,
    input  logic         rst,
    input  logic [23:0]  color,
    input  logic         valid,
    output logic         ready,
    output logic         done,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic         af_wr_en,
    output logic [2:0]   af_cmd_din,
    output logic [30:0]  af_addr_din,
    output logic         wdf_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2
    } state_t;

    state_t      state_r;
    logic [6:0]  x_r;
    logic [9:0]  y_r;
    logic [23:0] color_q_r;
    logic        done_r;

    // Address and first beat only go together, so a full address FIFO also
    // holds back the data beat in WR1.
    always_comb begin
        af_wr_en  = 1'b0;
        wdf_wr_en = 1'b0;
        case (state_r)
            WR1: begin
                af_wr_en  = !af_full && !wdf_full;
                wdf_wr_en = !af_full && !wdf_full;
            end
            WR2: begin
                af_wr_en  = 1'b0;
                wdf_wr_en = !wdf_full;
            end
            default: begin
                af_wr_en  = 1'b0;
                wdf_wr_en = 1'b0;
            end
        endcase
    end

    // Burst sequencer: walks x across each row, y down the frame.
    always_ff @(posedge cpu_clk_g) begin
        if (rst) begin
            state_r   <= IDLE;
            x_r       <= 7'd0;
            y_r       <= 10'd0;
            color_q_r <= 24'd0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid) begin
                        color_q_r <= color;
                        x_r       <= 7'd0;
                        y_r       <= 10'd0;
                        state_r   <= WR1;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                WR1: begin
                    if (!af_full && !wdf_full) begin
                        state_r <= WR2;
                    end else begin
                        state_r <= WR1;
                    end
                end
                WR2: begin
                    if (!wdf_full) begin
                        if (x_r == LAST_X && y_r == LAST_Y) begin
                            x_r     <= 7'd0;
                            y_r     <= 10'd0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else if (x_r == LAST_X) begin
                            x_r     <= 7'd0;
                            y_r     <= y_r + 10'd1;
                            state_r <= WR1;
                        end else begin
                            x_r     <= x_r + 7'd1;
                            state_r <= WR1;
                        end
                    end else begin
                        state_r <= WR2;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready        = (state_r == IDLE);
    assign done         = done_r;
    assign af_cmd_din   = 3'b000;
    assign af_addr_din  = {6'b000000, FB_BASE, y_r, x_r, 2'b00};
    assign wdf_din      = {4{8'h00, color_q_r}};
    assign wdf_mask_din = 16'h0000;

endmodule

// File: tb/tb_frame_filler.sv
// Scoreboard bench for frame_filler: the driver queues expected FIFO pushes,
// a negedge monitor pops and compares them as the DUT presents pushes.
module tb_frame_filler;

    // Frame height shortened to 60 rows to keep run length modest.
    localparam logic [9:0] TB_LAST_Y = 10'd59;
    localparam int         BURSTS    = 100 * 60;
    localparam int         BEATS     = 2 * BURSTS;

    logic         cpu_clk_g = 1'b0;
    logic         rst;
    logic [23:0]  color;
    logic         valid;
    logic         ready;
    logic         done;
    logic         af_full;
    logic         wdf_full;
    logic         af_wr_en;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    frame_filler #(
        .FB_BASE (6'd1),
        .LAST_X  (7'd99),
        .LAST_Y  (TB_LAST_Y)
    ) dut (
        .cpu_clk_g    (cpu_clk_g),
        .rst          (rst),
        .color        (color),
        .valid        (valid),
        .ready        (ready),
        .done         (done),
        .af_full      (af_full),
        .wdf_full     (wdf_full),
        .af_wr_en     (af_wr_en),
        .af_cmd_din   (af_cmd_din),
        .af_addr_din  (af_addr_din),
        .wdf_wr_en    (wdf_wr_en),
        .wdf_din      (wdf_din),
        .wdf_mask_din (wdf_mask_din)
    );

    always #5 cpu_clk_g = ~cpu_clk_g;

    int cyc = 0;
    always @(posedge cpu_clk_g) cyc <= cyc + 1;

    logic [30:0]  af_q[$];
    logic [127:0] wdf_q[$];
    int tests = 0;
    int fails = 0;
    int af_idx = 0;
    int wdf_idx = 0;
    int done_seen = 0;
    int last_push_cyc = 0;
    int accept_cyc = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pushes for one full frame, hand address formula from the map.
    task automatic queue_frame(input logic [23:0] c);
        for (int y = 0; y <= int'(TB_LAST_Y); y++) begin
            for (int x = 0; x <= 99; x++) begin
                af_q.push_back({6'd0, 6'd1, 10'(y), 7'(x), 2'd0});
                wdf_q.push_back({4{8'h00, c}});
                wdf_q.push_back({4{8'h00, c}});
            end
        end
    endtask

    task automatic request(input logic [23:0] c);
        int n;
        n = 0;
        queue_frame(c);
        color = c;
        valid = 1'b1;
        while (!ready && n < 100) begin
            @(posedge cpu_clk_g); #1;
            n++;
        end
        if (n >= 100) check("ready_timeout", 0, 1);
        @(posedge cpu_clk_g); #1;
        accept_cyc = cyc;
        valid = 1'b0;
        color = ~c;
    endtask

    task automatic wait_done(input string name, input bit check_len);
        int n;
        n = 0;
        @(negedge cpu_clk_g);
        while (!done && n < 20000) begin
            @(negedge cpu_clk_g);
            n++;
        end
        if (n >= 20000) check({name, "_timeout"}, 0, 1);
        else if (check_len) check({name, "_cycles"}, cyc - accept_cyc, BEATS);
        @(posedge cpu_clk_g); #1;
    endtask

    // Monitor: pops and compares on every push and done pulse.
    always @(negedge cpu_clk_g) begin
        logic [30:0]  ea;
        logic [127:0] ed;
        if (rst) begin
            af_idx  = 0;
            wdf_idx = 0;
        end else begin
            if (af_wr_en) begin
                if (af_q.size() == 0) begin
                    check("af_unexpected_push", 1, 0);
                end else begin
                    ea = af_q.pop_front();
                    check("af_cmd_addr", {af_cmd_din, af_addr_din}, {3'b000, ea});
                end
                case (af_idx)
                    0:          check("addr_first", af_addr_din, 31'h0080000);
                    1:          check("addr_second", af_addr_din, 31'h0080004);
                    100:        check("addr_101st", af_addr_din, 31'h0080200);
                    BURSTS - 1: check("addr_last", af_addr_din, 31'h008778C);
                    default:    ;
                endcase
                af_idx++;
            end
            if (wdf_wr_en) begin
                if (wdf_q.size() == 0) begin
                    check("wdf_unexpected_push", 1, 0);
                end else begin
                    ed = wdf_q.pop_front();
                    check("wdf_mask_data", {wdf_mask_din, wdf_din}, {16'h0000, ed});
                end
                wdf_idx++;
                last_push_cyc = cyc;
            end
            if (done) begin
                check("done_ready", ready, 1);
                check("done_beats", wdf_idx, BEATS);
                check("done_after_last_push", cyc - last_push_cyc, 1);
                done_seen++;
                af_idx  = 0;
                wdf_idx = 0;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; valid = 1'b0; color = 24'h0; af_full = 1'b0; wdf_full = 1'b0;
        repeat (2) @(posedge cpu_clk_g);
        #1 rst = 1'b0;
        @(negedge cpu_clk_g);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_enables", {af_wr_en, wdf_wr_en}, 2'b00);
        @(posedge cpu_clk_g); #1;

        // Frame 1: no backpressure, with an ignored mid-frame request.
        request(24'h12AB34);
        repeat (100) @(posedge cpu_clk_g);
        #1;
        valid = 1'b1;
        color = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk_g);
            check("midframe_ready_low", ready, 0);
        end
        @(posedge cpu_clk_g); #1;
        valid = 1'b0;
        wait_done("frame1", 1'b1);

        // Frame 2: stalls on af_full and wdf_full, then reset at burst 3000.
        request(24'h00FF01);
        af_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk_g);
            check("af_stall_enables", {af_wr_en, wdf_wr_en}, 2'b00);
            check("af_stall_addr", af_addr_din, 31'h0080000);
            @(posedge cpu_clk_g); #1;
        end
        af_full = 1'b0;
        @(negedge cpu_clk_g);
        check("af_release_pair", {af_wr_en, wdf_wr_en}, 2'b11);
        @(posedge cpu_clk_g); #1;
        wdf_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge cpu_clk_g);
            check("wdf_stall_enables", {af_wr_en, wdf_wr_en}, 2'b00);
            check("wdf_stall_addr", af_addr_din, 31'h0080000);
            @(posedge cpu_clk_g); #1;
        end
        wdf_full = 1'b0;
        @(negedge cpu_clk_g);
        check("wdf_release_push", {af_wr_en, wdf_wr_en}, 2'b01);
        @(negedge cpu_clk_g);
        check("x_advanced", af_addr_din, 31'h0080004);
        @(posedge cpu_clk_g); #1;
        n = 0;
        while (af_idx < 3000 && n < 10000) begin
            @(posedge cpu_clk_g); #1;
            n++;
        end
        if (n >= 10000) check("burst3000_timeout", 0, 1);
        rst = 1'b1;
        @(posedge cpu_clk_g);
        @(negedge cpu_clk_g);
        check("midrst_ready", ready, 1);
        check("midrst_enables", {af_wr_en, wdf_wr_en}, 2'b00);
        check("midrst_addr", af_addr_din, 31'h0080000);
        af_q.delete();
        wdf_q.delete();
        @(posedge cpu_clk_g); #1;
        rst = 1'b0;
        repeat (5) @(posedge cpu_clk_g);
        #1;

        // Frame 3: restart after the abandoned frame.
        request(24'hA55A0F);
        wait_done("frame3", 1'b1);

        repeat (3) @(posedge cpu_clk_g);
        check("done_count", done_seen, 2);
        check("af_queue_drained", af_q.size(), 0);
        check("wdf_queue_drained", wdf_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_filler.md
# frame_filler

Write-side DDR2 engine that fills the 800x600 frame buffer with one 24-bit colour. It pushes write commands into the DDR2 address FIFO and pixel data into the write-data FIFO, using the same framebuffer address map the display read path consumes. It runs on the CPU clock and is started by a single valid/ready handshake from the CPU's memory-mapped I/O.

## Interface
Parameters:
- FB_BASE, 6'd1, framebuffer region select placed in address bits [24:19]
- LAST_X, 7'd99, last 8-pixel block index in a row (100 blocks per row)
- LAST_Y, 10'd599, last row index

Ports:
- cpu_clk_g  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- color  in  24  fill colour {R,G,B}; sampled only on an accepted handshake
- valid  in  1  fill request
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse when the last beat of the frame is accepted
- af_full  in  1  address FIFO full
- wdf_full  in  1  write-data FIFO full
- af_wr_en  out  1  address/command push
- af_cmd_din  out  3  constant 3'b000 (write)
- af_addr_din  out  31  {6'b0, FB_BASE, y[9:0], x[6:0], 2'b0}
- wdf_wr_en  out  1  write-data push
- wdf_din  out  128  {4{8'h00, color_q}}
- wdf_mask_din  out  16  constant 16'h0000 (all bytes written)

## Operation
- Registers: state (IDLE, WR1, WR2), x[6:0], y[9:0], color_q[23:0], done.
- One burst = one address + two 128-bit beats = 8 pixels. Frame = 60000 bursts = 120000 beats.
- IDLE: ready=1. valid && ready -> color_q <= color, x <= 0, y <= 0, state <= WR1.
- WR1: go = !af_full && !wdf_full. af_wr_en = wdf_wr_en = go (address and first beat in the same cycle). go -> WR2; else stay, no pushes.
- WR2: wdf_wr_en = !wdf_full. On push: if x==LAST_X && y==LAST_Y -> x,y <= 0, done <= 1, state <= IDLE; else if x==LAST_X -> x <= 0, y <= y+1, state <= WR1; else x <= x+1, state <= WR1.
- af_wr_en and wdf_wr_en are combinational from state and full flags; they are never asserted in IDLE.
- af_addr_din and wdf_din are driven from registers and stay stable while stalled.
- valid during WR1/WR2 is ignored; color_q does not change mid-frame.
- Both full flags high in WR1 -> stall. af_full alone in WR1 -> stall (no lone data beat). af_full in WR2 is don't-care.

## Timing
- Reset values: state=IDLE, ready=1, done=0, x=0, y=0, color_q=0, af_wr_en=0, wdf_wr_en=0.
- Handshake accepted at edge N -> first pushes possible in cycle N+1.
- No backpressure: 2 cycles per burst, 120000 cycles per frame; done pulses on the edge after the final WR2 push, with ready=1 in that same cycle.
- A new valid is accepted on the edge after done at the earliest.
- rst mid-frame: next edge -> IDLE, counters 0, enables low. A partly written burst is abandoned; the DDR2 side is reset by the same rst.
- Address arithmetic: x wraps at LAST_X; y wraps only at frame end. No carry into FB_BASE bits.

## Test plan
- Reset: assert rst for 2 cycles -> ready=1, done=0, af_wr_en=0, wdf_wr_en=0 on release.
- Full fill, no backpressure, color=24'h12AB34 -> 60000 af pushes, 120000 wdf pushes. First address 31'h0080000, second 31'h0080004, 101st 31'h0080200, last 31'h00CAF8C. Every wdf_din = {4{32'h0012AB34}}. Exactly one done pulse at cycle 120000.
- Hold af_full=1 for 10 cycles in WR1 -> no pushes, af_addr_din unchanged. Release -> address plus beat in the same cycle.
- Hold wdf_full=1 for 5 cycles in WR2 -> wdf_wr_en=0, x unchanged. Release -> one push, then x advances.
- valid with color=24'hFFFFFF mid-frame -> ignored, ready=0, wdf_din keeps the original colour.
- Assert rst at burst 3000 -> IDLE next cycle, no further pushes. New request -> restarts at 31'h0080000.
